rll_key_loader: RTL and testbench

RLL_KEY_LOADER -- requirements
Module: rll_key_loader

---
 rtl/rll_key_pkg.sv | 15 +
 rtl/rll_key_shreg.sv | 35 +++
 rtl/rll_key_loader.sv | 115 +++++++++++
 tb/tb_rll_key_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
// Shared widths and FSM state encoding for the serial key loader of the locked netlist.
package rll_key_pkg;

    localparam int KEY_W = 16;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARMED = 3'd3,
        ST_ERROR = 3'd4
    } key_state_e;

endpackage

// File: rtl/rll_key_shreg.sv
// Shadow shift register (MSB-first) plus the running even-parity accumulator.
module rll_key_shreg
    import rll_key_pkg::*;
#(
    parameter int KEY_W = rll_key_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             par_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             parity
);

    // clr outranks both enables so a restart never keeps a stray bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            shadow <= '0;
            parity <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow <= {shadow[KEY_W-2:0], bit_in};
            end
            if (par_en) begin
                parity <= parity ^ bit_in;
            end
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts KEY_W key bits plus one even-parity bit, then arms key_out.
//   state    | meaning
//   ST_IDLE  | no load in progress, key_out cleared
//   ST_SHIFT | accepting key bits and the trailing parity bit
//   ST_CHECK | one cycle: evaluate parity of all KEY_W+1 bits
//   ST_ARMED | key_out holds a parity-checked key
//   ST_ERROR | last load failed parity, key_out held at zero
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W = rll_key_pkg::KEY_W,
    parameter int CNT_W = rll_key_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             key_armed,
    output logic             load_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_KEY = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(KEY_W + 1);

    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] shadow;
    logic             parity;
    logic             accept;
    logic             clr;
    logic             shift_en;
    logic             par_en;

    // key_ready is registered high exactly while in ST_SHIFT
    assign accept   = key_ready & key_valid;
    assign clr      = zeroize | load_start;
    assign shift_en = accept & ~clr & (cnt < CNT_KEY);
    assign par_en   = accept & ~clr;

    rll_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_en),
        .par_en   (par_en),
        .bit_in   (key_bit),
        .shadow   (shadow),
        .parity   (parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_out   <= '0;
            key_armed <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
        end else if (zeroize) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_out   <= '0;
            key_armed <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
        end else if (load_start) begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            key_out   <= '0;
            key_armed <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b1;
            key_ready <= 1'b1;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (accept) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        // the accepted bit at count KEY_W is the parity bit
                        if (cnt == CNT_KEY) begin
                            state     <= ST_CHECK;
                            key_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (!parity) begin
                        key_out   <= shadow;
                        key_armed <= 1'b1;
                        state     <= ST_ARMED;
                    end else begin
                        load_err <= 1'b1;
                        state    <= ST_ERROR;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: expected load outcomes are queued at stimulus time.
module tb_rll_key_loader;

    localparam int KW = 16;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          armed;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          key_bit;
    logic          key_valid;
    logic          key_ready;
    logic          zeroize;
    logic [KW-1:0] key_out;
    logic          key_armed;
    logic          load_err;
    logic          busy;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    rll_key_loader #(
        .KEY_W (KW),
        .CNT_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .zeroize    (zeroize),
        .key_out    (key_out),
        .key_armed  (key_armed),
        .load_err   (load_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        if (gap > 0) begin
            key_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        key_valid = 1'b1;
        key_bit   = b;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_key_out", key_out, 0);
        chk("start_armed", key_armed, 0);
        chk("start_err", load_err, 0);
        chk("start_busy", busy, 1);
        chk("start_ready", key_ready, 1);
    endtask

    task automatic do_load(input logic [KW-1:0] k, input logic p, input int gap);
        exp_t e;
        int   t;
        if ((^{k, p}) == 1'b0) e = '{key: k, armed: 1'b1, err: 1'b0};
        else                   e = '{key: '0, armed: 1'b0, err: 1'b1};
        sb.push_back(e);
        pulse_start();
        for (int i = 0; i < KW; i++) send_bit(k[KW-1-i], gap);
        send_bit(p, gap);
        key_valid = 1'b0;
        chk("check_busy", busy, 1);
        chk("check_ready", key_ready, 0);
        chk("check_key_hidden", key_out, 0);
        t = 0;
        while (busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("check_latency", t, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("load_key_out", key_out, e.key);
            chk("load_armed", key_armed, e.armed);
            chk("load_err", load_err, e.err);
            chk("load_ready", key_ready, 0);
        end
    endtask

    initial begin
        logic [KW-1:0] held;
        logic [KW-1:0] k00ff;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        load_start = 1'b0;
        key_bit    = 1'b0;
        key_valid  = 1'b0;
        zeroize    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_key_out", key_out, 0);
        chk("rst_armed", key_armed, 0);
        chk("rst_err", load_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", key_ready, 0);
        rst_n = 1'b1;

        // bits without load_start must not start a load
        key_valid = 1'b1;
        key_bit   = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ready", key_ready, 0);
        chk("idle_busy", busy, 0);
        key_valid = 1'b0;

        do_load(16'hA5C3, 1'b0, 0);

        // ARMED holds against stray bits
        held = key_out;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'($urandom_range(1, 0));
            key_bit   = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk("armed_hold", key_out, 16'hA5C3);
        end
        chk("armed_hold_flag", key_armed, 1);
        key_valid = 1'b0;

        do_load(16'hA5C3, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("error_hold_err", load_err, 1);
        chk("error_hold_key", key_out, 0);

        do_load(16'h8001, 1'b0, 2);

        // zeroize after 7 bits, coincident with a bit accept
        k00ff = 16'h00FF;
        pulse_start();
        for (int i = 0; i < 7; i++) send_bit(k00ff[KW-1-i], 0);
        zeroize   = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("zero_key_out", key_out, 0);
        chk("zero_busy", busy, 0);
        chk("zero_ready", key_ready, 0);
        @(negedge clk);
        chk("zero_stays_idle", key_ready, 0);
        key_valid = 1'b0;
        do_load(16'h00FF, 1'b0, 0);

        // restart mid-shift, with a bit accepted on the restart edge
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        do_load(16'h8001, 1'b0, 0);

        // async reset while armed
        do_load(16'h1234, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_key_out", key_out, 0);
        chk("async_armed", key_armed, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", key_ready, 0);

        // zeroize beats a simultaneous load_start
        do_load(16'h1234, 1'b1, 1);
        zeroize    = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        zeroize    = 1'b0;
        load_start = 1'b0;
        chk("zl_key_out", key_out, 0);
        chk("zl_armed", key_armed, 0);
        chk("zl_busy", busy, 0);
        chk("zl_ready", key_ready, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
